// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Opcodes, R-type funct codes, ALU operation codes and mux-select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXEC,
    S_ALUWB,
    S_ADDIEXEC,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PC_ALURES = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_DATA   = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps aluop/funct to an ALU operation code, zero-extended
// to the configured width, and flags R-type funct values it cannot execute.
module mc_aludec
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 5
) (
  input  aluop_t               aluop,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_illegal
);

  logic [2:0] funct_code;
  logic [2:0] code;

  always_comb begin
    funct_code    = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      F_ADD:   funct_code = ALU_ADD;
      F_SUB:   funct_code = ALU_SUB;
      F_AND:   funct_code = ALU_AND;
      F_OR:    funct_code = ALU_OR;
      F_SLT:   funct_code = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   code = ALU_ADD;
      ALUOP_SUB:   code = ALU_SUB;
      ALUOP_FUNCT: code = funct_code;
      default:     code = ALU_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 cycles,
// stretching FETCH/MEMRD/MEMWR until the memory reports completion.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 5,
  parameter bit          HAS_BNE   = 1'b1,
  parameter bit          HAS_JAL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 memreq,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 pcen,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [1:0]           memtoreg,
  output logic [1:0]           regdst,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  state_t               state;
  state_t               decode_next;
  logic                 decode_illegal;
  logic                 funct_illegal;
  aluop_t               aluop;
  logic                 alu_en;
  logic [ALUCTRL_W-1:0] alu_code;

  logic       memreq_c, iord_c, memwrite_c, irwrite_c, pcen_c, regwrite_c;
  logic       alusrca_c, illegal_c;
  logic [1:0] alusrcb_c, pcsrc_c, memtoreg_c, regdst_c;

  mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alu_code),
    .funct_illegal (funct_illegal)
  );

  // Dispatch out of DECODE; unsupported encodings fall back to FETCH.
  always_comb begin
    decode_next    = S_FETCH;
    decode_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (HAS_JAL && funct == F_JR) decode_next = S_JR;
        else if (funct_illegal)       decode_illegal = 1'b1;
        else                          decode_next = S_RTEXEC;
      end
      OP_ADDI: decode_next = S_ADDIEXEC;
      OP_BEQ:  decode_next = S_BRANCH;
      OP_BNE: begin
        if (HAS_BNE) decode_next = S_BRANCH;
        else         decode_illegal = 1'b1;
      end
      OP_J: decode_next = S_JUMP;
      OP_JAL: begin
        if (HAS_JAL) decode_next = S_JAL;
        else         decode_illegal = 1'b1;
      end
      default: decode_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next;
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (mem_ready) state <= S_MEMWB;
        S_MEMWR:    if (mem_ready) state <= S_FETCH;
        S_RTEXEC:   state <= S_ALUWB;
        S_ADDIEXEC: state <= S_ADDIWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    memreq_c   = 1'b0;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcen_c     = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = SRCB_RT;
    pcsrc_c    = PC_ALURES;
    memtoreg_c = WB_ALUOUT;
    regdst_c   = DST_RT;
    aluop      = ALUOP_ADD;
    alu_en     = 1'b0;
    illegal_c  = 1'b0;
    case (state)
      S_FETCH: begin
        memreq_c  = 1'b1;
        alusrcb_c = SRCB_FOUR;
        alu_en    = 1'b1;
        irwrite_c = mem_ready;
        pcen_c    = mem_ready;
      end
      S_DECODE: begin
        alusrcb_c = SRCB_IMMSH;
        alu_en    = 1'b1;
        illegal_c = decode_illegal;
      end
      S_MEMADR, S_ADDIEXEC: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        alu_en    = 1'b1;
      end
      S_MEMRD: begin
        memreq_c = 1'b1;
        iord_c   = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_c = WB_DATA;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        memreq_c   = 1'b1;
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTEXEC: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_FUNCT;
        alu_en    = 1'b1;
      end
      S_ALUWB: begin
        regdst_c   = DST_RD;
        regwrite_c = 1'b1;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_BRANCH: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_SUB;
        alu_en    = 1'b1;
        pcsrc_c   = PC_ALUOUT;
        pcen_c    = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
      end
      S_JUMP: begin
        pcsrc_c = PC_JUMP;
        pcen_c  = 1'b1;
      end
      S_JAL: begin
        pcsrc_c    = PC_JUMP;
        pcen_c     = 1'b1;
        regdst_c   = DST_RA;
        memtoreg_c = WB_PC;
        regwrite_c = 1'b1;
      end
      S_JR: begin
        pcsrc_c = PC_RS;
        pcen_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced low by the reset input itself so an asynchronous
  // assertion kills any in-flight strobe without waiting for a clock edge.
  assign memreq     = reset & memreq_c;
  assign iord       = reset & iord_c;
  assign memwrite   = reset & memwrite_c;
  assign irwrite    = reset & irwrite_c;
  assign pcen       = reset & pcen_c;
  assign regwrite   = reset & regwrite_c;
  assign alusrca    = reset & alusrca_c;
  assign illegal    = reset & illegal_c;
  assign alusrcb    = reset ? alusrcb_c  : '0;
  assign pcsrc      = reset ? pcsrc_c    : '0;
  assign memtoreg   = reset ? memtoreg_c : '0;
  assign regdst     = reset ? regdst_c   : '0;
  assign alucontrol = (reset && alu_en) ? alu_code : '0;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams compared cycle by cycle against a sequence model.
module tb_mc_controller;

  typedef struct packed {
    logic       memreq, iord, memwrite, irwrite, pcen, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, memtoreg, regdst;
    logic [4:0] alu;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic  mr;
    outs_t o;
    string tag;
  } step_t;

  logic clk = 1'b0;
  logic reset, rst1;
  logic [5:0] op, funct;
  logic zero, mem_ready;

  logic memreq, iord, memwrite, irwrite, pcen, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, memtoreg, regdst;
  logic [4:0] alucontrol;

  logic b_memreq, b_iord, b_memwrite, b_irwrite, b_pcen, b_regwrite, b_alusrca, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc, b_memtoreg, b_regdst;
  logic [2:0] b_alucontrol;

  outs_t got;
  assign got = {memreq, iord, memwrite, irwrite, pcen, regwrite, alusrca,
                alusrcb, pcsrc, memtoreg, regdst, alucontrol, illegal};

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memreq(memreq), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .memtoreg(memtoreg), .regdst(regdst), .alucontrol(alucontrol), .illegal(illegal)
  );

  mc_controller #(.ALUCTRL_W(3), .HAS_BNE(1'b0), .HAS_JAL(1'b0)) dut_min (
    .clk(clk), .reset(rst1), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memreq(b_memreq), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .pcen(b_pcen),
    .regwrite(b_regwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb), .pcsrc(b_pcsrc),
    .memtoreg(b_memtoreg), .regdst(b_regdst), .alucontrol(b_alucontrol), .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  step_t q[$];

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, g, e);
    end
  endtask

  function automatic logic [4:0] rcode(input logic [5:0] f);
    case (f)
      6'h20:   return 5'd2;
      6'h22:   return 5'd6;
      6'h24:   return 5'd0;
      6'h25:   return 5'd1;
      6'h2a:   return 5'd7;
      default: return 5'd0;
    endcase
  endfunction

  function automatic outs_t fetch_o(input logic ready);
    outs_t o = '0;
    o.memreq = 1'b1; o.alusrcb = 2'd1; o.alu = 5'd2;
    o.irwrite = ready; o.pcen = ready;
    return o;
  endfunction

  task automatic push(input logic mr, input outs_t o, input string t);
    step_t s;
    s.mr = mr; s.o = o; s.tag = t;
    q.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle outputs for one instruction with given wait counts
  // (fw cycles of not-ready in fetch, mw in the data access).
  task automatic model(input logic [5:0] o_op, input logic [5:0] fn, input logic z,
                       input int unsigned fw, input int unsigned mw);
    outs_t o;
    logic  ok;
    for (int unsigned i = 0; i < fw; i++) push(1'b0, fetch_o(1'b0), "FETCH_wait");
    push(1'b1, fetch_o(1'b1), "FETCH");
    case (o_op)
      6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03: ok = 1'b1;
      6'h00: ok = (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08});
      default: ok = 1'b0;
    endcase
    o = '0; o.alusrcb = 2'd3; o.alu = 5'd2; o.illegal = ~ok;
    push(rnd_bit(), o, "DECODE");
    if (!ok) return;
    case (o_op)
      6'h23, 6'h2b: begin
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'd2; o.alu = 5'd2;
        push(rnd_bit(), o, "MEMADR");
        o = '0; o.memreq = 1'b1; o.iord = 1'b1; o.memwrite = (o_op == 6'h2b);
        for (int unsigned i = 0; i < mw; i++) push(1'b0, o, "MEM_wait");
        push(1'b1, o, "MEM");
        if (o_op == 6'h23) begin
          o = '0; o.regwrite = 1'b1; o.memtoreg = 2'd1;
          push(rnd_bit(), o, "MEMWB");
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          o = '0; o.pcsrc = 2'd3; o.pcen = 1'b1;
          push(rnd_bit(), o, "JR");
        end else begin
          o = '0; o.alusrca = 1'b1; o.alu = rcode(fn);
          push(rnd_bit(), o, "RTEXEC");
          o = '0; o.regdst = 2'd1; o.regwrite = 1'b1;
          push(rnd_bit(), o, "ALUWB");
        end
      end
      6'h08: begin
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'd2; o.alu = 5'd2;
        push(rnd_bit(), o, "ADDIEXEC");
        o = '0; o.regwrite = 1'b1;
        push(rnd_bit(), o, "ADDIWB");
      end
      6'h04, 6'h05: begin
        o = '0; o.alusrca = 1'b1; o.alu = 5'd6; o.pcsrc = 2'd1;
        o.pcen = (o_op == 6'h04) ? z : ~z;
        push(rnd_bit(), o, "BRANCH");
      end
      6'h02: begin
        o = '0; o.pcsrc = 2'd2; o.pcen = 1'b1;
        push(rnd_bit(), o, "JUMP");
      end
      default: begin
        o = '0; o.pcsrc = 2'd2; o.pcen = 1'b1; o.regdst = 2'd2;
        o.memtoreg = 2'd2; o.regwrite = 1'b1;
        push(rnd_bit(), o, "JAL");
      end
    endcase
  endtask

  task automatic run();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.mr;
      #1;
      chk(s.tag, 32'(got), 32'(s.o));
      @(negedge clk);
    end
  endtask

  task automatic instr(input logic [5:0] o_op, input logic [5:0] fn, input logic z,
                       input int unsigned fw, input int unsigned mw);
    op = o_op; funct = fn; zero = z;
    model(o_op, fn, z, fw, mw);
    run();
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [7];
  logic [5:0] bops [3];
  logic [5:0] bfns [3];

  initial begin
    ops  = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f, 6'h0c};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h00};
    bops = '{6'h05, 6'h03, 6'h00};
    bfns = '{6'h20, 6'h20, 6'h08};

    reset = 1'b0; rst1 = 1'b0; mem_ready = 1'b1; op = 6'h23; funct = 6'h20; zero = 1'b0;
    #3;
    chk("reset_outputs", 32'(got), 32'h0);
    chk("reset_outputs_min", {b_memreq, b_irwrite, b_pcen, b_alusrcb, b_alucontrol}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", 32'(got), 32'h0);
    reset = 1'b1;

    instr(6'h23, 6'h20, 1'b0, 0, 0);
    instr(6'h2b, 6'h20, 1'b0, 0, 3);
    instr(6'h04, 6'h20, 1'b1, 0, 0);
    instr(6'h05, 6'h20, 1'b1, 0, 0);
    instr(6'h05, 6'h20, 1'b0, 1, 0);
    instr(6'h03, 6'h20, 1'b0, 0, 0);
    instr(6'h00, 6'h08, 1'b0, 0, 0);
    instr(6'h00, 6'h22, 1'b0, 0, 0);
    instr(6'h00, 6'h00, 1'b0, 0, 0);
    instr(6'h08, 6'h00, 1'b0, 2, 0);
    instr(6'h02, 6'h00, 1'b0, 0, 0);
    instr(6'h23, 6'h2a, 1'b0, 1, 2);

    // Asynchronous reset while lw waits in MEMRD.
    op = 6'h23; funct = 6'h20;
    model(6'h23, 6'h20, 1'b0, 0, 5);
    while (q.size() > 4) void'(q.pop_back());
    run();
    mem_ready = 1'b0;
    #1;
    chk("memrd_waiting", {memreq, iord, regwrite}, 32'h6);
    #2 reset = 1'b0;
    #1;
    chk("abort_outputs", 32'(got), 32'h0);
    @(posedge clk);
    #1;
    chk("abort_hold", 32'(got), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    instr(6'h2b, 6'h25, 1'b0, 0, 1);

    // Reduced build: no bne/jal/jr, 3-bit ALU control.
    @(negedge clk);
    reset = 1'b0;
    rst1  = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op = bops[k]; funct = bfns[k];
      #1;
      chk("min_fetch", {b_memreq, b_irwrite, b_illegal}, 32'h6);
      @(negedge clk);
      #1;
      chk("min_illegal", {b_illegal, b_memreq}, 32'h2);
      @(negedge clk);
    end
    op = 6'h04; zero = 1'b1;
    #1;
    chk("min_fetch_beq", {b_memreq, b_irwrite, b_illegal}, 32'h6);
    @(negedge clk);
    #1;
    chk("min_decode_beq", {b_illegal, b_alucontrol}, 32'h2);
    @(negedge clk);
    #1;
    chk("min_branch", {b_pcsrc, b_pcen, b_alucontrol}, 32'h1e);
    chk("dut_held_reset", 32'(got), 32'h0);
    @(negedge clk);
    #1;
    chk("min_back_fetch", {b_memreq, b_irwrite}, 32'h3);
    rst1 = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 80; n++) begin
      instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 6)], rnd_bit(),
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
